fft_cfg_reg_bank: RTL and testbench

// - Parametrised configuration register bank for the FFT datapath; the next generation of the single point-config register.
// - Holds NUM_REGS config words: word 0 is the point config, words 1..NUM_REGS-1 are general mode words.
// - Host-side writes land in a shadow copy. A commit FSM copies shadow to active only while the FFT is idle.
//   The engine therefore never sees a configuration change in the middle of a frame.

---
 rtl/fft_cfg_reg_bank.sv | 154 +++++++++++++++
 tb/tb_fft_cfg_reg_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cfg_reg_bank.sv
// rtl/fft_cfg_reg_bank.sv - FFT configuration register bank, shadow/active with idle-gated commit FSM
// Optional illegal-address error pulse is built only when CFG_ERR_EN is defined.
module fft_cfg_reg_bank #(
    parameter int NUM_REGS  = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int PNT_W     = 3,
    parameter int PNT_MAX   = 7,
    parameter int RESET_VAL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_wen,
    input  logic                       cfg_ren,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]          cfg_wdata,
    output logic [DATA_W-1:0]          cfg_rdata,
    output logic                       cfg_ready,
    input  logic                       commit_req,
    input  logic                       fft_busy,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active,
    output logic                       cfg_pending,
    output logic                       cfg_done,
    output logic                       cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_APPLY
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;

    logic              addr_ok;
    logic              wr_ok;
    logic              rd_go;
    logic [PNT_W-1:0]  pnt_raw;
    logic [PNT_W-1:0]  pnt_clamped;

    // Widened compares keep the range checks meaningful for every parameter set.
    assign addr_ok     = {1'b0, cfg_addr} < (ADDR_W+1)'(NUM_REGS);
    assign wr_ok       = cfg_wen && addr_ok;
    assign rd_go       = cfg_ren && !cfg_wen;
    assign pnt_raw     = cfg_wdata[PNT_W-1:0];
    assign pnt_clamped = ({1'b0, pnt_raw} > (PNT_W+1)'(PNT_MAX)) ? PNT_W'(PNT_MAX) : pnt_raw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_req && pending_q) begin
                    state_d = fft_busy ? ST_WAIT : ST_APPLY;
                end
            end
            ST_WAIT: begin
                if (!fft_busy) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d   = '0;
        ready_d   = rd_go;
        pending_d = pending_q;
        done_d    = (state_q == ST_APPLY);
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            // Active samples the pre-write shadow, so a write in APPLY waits for the next commit.
            if (state_q == ST_APPLY) begin
                active_d[i] = shadow_q[i];
            end
            if (wr_ok && cfg_addr == ADDR_W'(i)) begin
                shadow_d[i] = (i == 0) ? DATA_W'(pnt_clamped) : cfg_wdata;
            end
            if (rd_go && cfg_addr == ADDR_W'(i)) begin
                rdata_d = shadow_q[i];
            end
        end
        if (state_q == ST_APPLY) begin
            pending_d = 1'b0;
        end
        if (wr_ok) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= DATA_W'(RESET_VAL);
                active_q[i] <= DATA_W'(RESET_VAL);
            end
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_active[i*DATA_W +: DATA_W] = active_q[i];
        end
    end

    assign cfg_rdata   = rdata_q;
    assign cfg_ready   = ready_q;
    assign cfg_pending = pending_q;
    assign cfg_done    = done_q;

`ifdef CFG_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (cfg_wen || cfg_ren) && !addr_ok;
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_cfg_reg_bank.sv
// tb/tb_fft_cfg_reg_bank.sv - directed bench for fft_cfg_reg_bank (default build and NUM_REGS=3/PNT_MAX=5 build)
module tb_fft_cfg_reg_bank;

`ifdef CFG_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wen;
    logic        cfg_ren;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        commit_req;
    logic        fft_busy;

    logic [7:0]  a_rdata,   b_rdata;
    logic        a_ready,   b_ready;
    logic [31:0] a_active;
    logic [23:0] b_active;
    logic        a_pending, b_pending;
    logic        a_done,    b_done;
    logic        a_err,     b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_cfg_reg_bank u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .cfg_wen     (cfg_wen),
        .cfg_ren     (cfg_ren),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (a_rdata),
        .cfg_ready   (a_ready),
        .commit_req  (commit_req),
        .fft_busy    (fft_busy),
        .cfg_active  (a_active),
        .cfg_pending (a_pending),
        .cfg_done    (a_done),
        .cfg_err     (a_err)
    );

    fft_cfg_reg_bank #(
        .NUM_REGS (3),
        .PNT_MAX  (5)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .cfg_wen     (cfg_wen),
        .cfg_ren     (cfg_ren),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (b_rdata),
        .cfg_ready   (b_ready),
        .commit_req  (commit_req),
        .fft_busy    (fft_busy),
        .cfg_active  (b_active),
        .cfg_pending (b_pending),
        .cfg_done    (b_done),
        .cfg_err     (b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_wen = 1'b0; cfg_ren = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 8'h00; commit_req = 1'b0; fft_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_rdata",   {24'h0, a_rdata}, 32'h0);
        chk("rst_ready",   {31'h0, a_ready}, 32'h0);
        chk("rst_pending", {31'h0, a_pending}, 32'h0);
        chk("rst_done",    {31'h0, a_done}, 32'h0);
        chk("rst_err",     {31'h0, a_err}, 32'h0);
        chk("rst_active_a", a_active, 32'h0);
        chk("rst_active_b", {8'h0, b_active}, 32'h0);

        // back-to-back reads of every address
        for (int i = 0; i < 4; i++) begin
            cfg_ren = 1'b1; cfg_addr = 2'(i);
            step();
            chk($sformatf("rd%0d_rdata_a", i), {24'h0, a_rdata}, 32'h0);
            chk($sformatf("rd%0d_ready_a", i), {31'h0, a_ready}, 32'h1);
            chk($sformatf("rd%0d_ready_b", i), {31'h0, b_ready}, 32'h1);
            chk($sformatf("rd%0d_err_b", i), {31'h0, b_err}, {31'h0, ERR_EN && (i == 3)});
        end
        cfg_ren = 1'b0;
        step();
        chk("idle_ready", {31'h0, a_ready}, 32'h0);

        // write point 5, commit while idle
        cfg_wen = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'hF5;
        step();
        chk("w0_pending", {31'h0, a_pending}, 32'h1);
        chk("w0_ready",   {31'h0, a_ready}, 32'h0);
        cfg_wen = 1'b0; commit_req = 1'b1;
        step();
        chk("apply_done0",   {31'h0, a_done}, 32'h0);
        chk("apply_active0", a_active, 32'h0);
        commit_req = 1'b0;
        step();
        chk("c1_active_a", a_active, 32'h0000_0005);
        chk("c1_active_b", {8'h0, b_active}, 32'h0000_0005);
        chk("c1_done",     {31'h0, a_done}, 32'h1);
        chk("c1_pending",  {31'h0, a_pending}, 32'h0);
        step();
        chk("c1_done_off", {31'h0, a_done}, 32'h0);

        // point 7: legal in A, clamps to 5 in B
        cfg_wen = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h07;
        step();
        cfg_wen = 1'b0; cfg_ren = 1'b1;
        step();
        cfg_ren = 1'b0;
        chk("clamp_rd_a", {24'h0, a_rdata}, 32'h07);
        chk("clamp_rd_b", {24'h0, b_rdata}, 32'h05);
        chk("clamp_act_a", a_active, 32'h0000_0005);

        // commit stalled by busy, extra write during WAIT
        cfg_wen = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'hA5;
        step();
        cfg_wen = 1'b0; commit_req = 1'b1; fft_busy = 1'b1;
        step();
        commit_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) begin
                cfg_wen = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h3C;
            end
            step();
            cfg_wen = 1'b0;
            chk($sformatf("wait%0d_done", k), {31'h0, a_done}, 32'h0);
        end
        fft_busy = 1'b0;
        step();
        chk("wait_act_hold", a_active, 32'h0000_0005);
        step();
        chk("wait_done",     {31'h0, a_done}, 32'h1);
        chk("wait_active_a", a_active, 32'h003C_A507);
        chk("wait_active_b", {8'h0, b_active}, 32'h003C_A505);
        chk("wait_pending",  {31'h0, a_pending}, 32'h0);
        step();
        chk("wait_done_off", {31'h0, a_done}, 32'h0);

        // same-cycle write and read: write wins
        cfg_wen = 1'b1; cfg_ren = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h5A;
        step();
        chk("wr_rd_ready", {31'h0, a_ready}, 32'h0);
        chk("wr_rd_rdata", {24'h0, a_rdata}, 32'h0);
        cfg_wen = 1'b0;
        step();
        cfg_ren = 1'b0;
        chk("wr_rd_back", {24'h0, a_rdata}, 32'h5A);

        // write landing in the APPLY cycle
        cfg_wen = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h11;
        step();
        cfg_wen = 1'b0; commit_req = 1'b1;
        step();
        commit_req = 1'b0; cfg_wen = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h22;
        step();
        cfg_wen = 1'b0;
        chk("apw_active_a", a_active, 32'h0011_5A07);
        chk("apw_active_b", {8'h0, b_active}, 32'h0011_5A05);
        chk("apw_pending",  {31'h0, a_pending}, 32'h1);
        chk("apw_done",     {31'h0, a_done}, 32'h1);
        cfg_ren = 1'b1;
        step();
        cfg_ren = 1'b0;
        chk("apw_shadow", {24'h0, a_rdata}, 32'h22);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step();
        chk("apw_commit2", a_active, 32'h0022_5A07);
        chk("apw_pend_b",  {31'h0, b_pending}, 32'h0);

        // address 3: legal in A, illegal in B
        cfg_wen = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'h99;
        step();
        cfg_wen = 1'b0;
        chk("ill_w_pend_a", {31'h0, a_pending}, 32'h1);
        chk("ill_w_pend_b", {31'h0, b_pending}, 32'h0);
        chk("ill_w_err_a",  {31'h0, a_err}, 32'h0);
        chk("ill_w_err_b",  {31'h0, b_err}, {31'h0, ERR_EN});
        cfg_ren = 1'b1;
        step();
        cfg_ren = 1'b0;
        chk("ill_r_rdata_a", {24'h0, a_rdata}, 32'h99);
        chk("ill_r_rdata_b", {24'h0, b_rdata}, 32'h0);
        chk("ill_r_ready_b", {31'h0, b_ready}, 32'h1);
        chk("ill_r_err_b",   {31'h0, b_err}, {31'h0, ERR_EN});
        step();
        chk("ill_err_off_b", {31'h0, b_err}, 32'h0);

        // commit_req without pending is ignored (B), honoured in A
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step();
        chk("nopend_done_a",   {31'h0, a_done}, 32'h1);
        chk("nopend_active_a", a_active, 32'h9922_5A07);
        chk("nopend_done_b",   {31'h0, b_done}, 32'h0);
        chk("nopend_active_b", {8'h0, b_active}, 32'h0022_5A05);

        // reset while waiting aborts the commit
        cfg_wen = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h77;
        step();
        cfg_wen = 1'b0; commit_req = 1'b1; fft_busy = 1'b1;
        step();
        commit_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; fft_busy = 1'b0;
        step();
        chk("abort_done",    {31'h0, a_done}, 32'h0);
        chk("abort_active",  a_active, 32'h0);
        chk("abort_pending", {31'h0, a_pending}, 32'h0);
        cfg_ren = 1'b1; cfg_addr = 2'd1;
        step();
        cfg_ren = 1'b0;
        chk("abort_done2",  {31'h0, a_done}, 32'h0);
        chk("abort_shadow", {24'h0, a_rdata}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
